// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin grant of a 4:1 lane mux into a registered valid/ready output stage
module mux_rr_arbiter #(
    parameter int LANE_W   = 4,
    parameter int MAX_HOLD = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            req,
    input  logic [3:0]            last,
    input  logic [4*LANE_W-1:0]   lane_data,
    output logic [3:0]            gnt,
    output logic [1:0]            sel,
    output logic [LANE_W-1:0]     out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy
);
    localparam int HW = $clog2(MAX_HOLD + 1);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t            r_state;
    logic [1:0]        r_ptr;
    logic [HW-1:0]     r_hold;
    logic [3:0]        r_gnt;
    logic [1:0]        r_sel;
    logic [LANE_W-1:0] r_data;
    logic              r_valid;
    logic              r_busy;
    logic [7:0]        w_dbl;
    logic [3:0]        w_rot;
    logic [1:0]        w_off;
    logic [1:0]        w_win;
    logic [LANE_W-1:0] w_lane;
    logic              w_beat;
    logic              w_rel;
    // Requests rotated so bit 0 is the pointer position; first set bit is the winner's offset.
    assign w_dbl  = {req, req};
    assign w_rot  = 4'(w_dbl >> r_ptr);
    assign w_off  = w_rot[0] ? 2'd0 : w_rot[1] ? 2'd1 : w_rot[2] ? 2'd2 : 2'd3;
    assign w_win  = r_ptr + w_off;
    assign w_lane = lane_data[r_sel*LANE_W +: LANE_W];
    assign w_beat = (r_state == GRANT) && req[r_sel] && (!r_valid || out_ready);
    assign w_rel  = (r_state == GRANT) &&
                    (!req[r_sel] || (w_beat && (last[r_sel] || r_hold == HW'(MAX_HOLD - 1))));
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_hold  <= '0;
            r_gnt   <= '0;
            r_sel   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            if (w_beat) begin
                r_data  <= w_lane;
                r_valid <= 1'b1;
                r_hold  <= r_hold + 1'b1;
            end else if (out_ready) begin
                r_valid <= 1'b0;
            end
            if (r_state == IDLE) begin
                if (|req) begin
                    r_gnt   <= 4'b1 << w_win;
                    r_sel   <= w_win;
                    r_hold  <= '0;
                    r_busy  <= 1'b1;
                    r_state <= GRANT;
                end
            end else if (w_rel) begin
                r_gnt   <= '0;
                r_ptr   <= r_sel + 2'd1;
                r_busy  <= 1'b0;
                r_state <= IDLE;
            end
        end
    end
    assign gnt       = r_gnt;
    assign sel       = r_sel;
    assign out_data  = r_data;
    assign out_valid = r_valid;
    assign busy      = r_busy;
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: directed vectors with hand-computed expectations for mux_rr_arbiter
module tb_mux_rr_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [3:0]  last = '0;
    logic [15:0] lane_data = '0;
    logic [3:0]  gnt;
    logic [1:0]  sel;
    logic [3:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        busy;
    int          total = 0;
    int          bad = 0;
    mux_rr_arbiter #(.LANE_W(4), .MAX_HOLD(4)) dut (
        .clk(clk), .rst(rst), .req(req), .last(last), .lane_data(lane_data),
        .gnt(gnt), .sel(sel), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    initial begin
        // reset with all requests asserted
        rst = 1'b1; req = 4'hF;
        tick(); tick();
        chk("rst_gnt", gnt, 0); chk("rst_sel", sel, 0);
        chk("rst_valid", out_valid, 0); chk("rst_busy", busy, 0);
        rst = 1'b0; req = 4'h0;
        tick();
        // single burst from requester 2
        lane_data = 16'h0A00; out_ready = 1'b1; last = 4'h0; req = 4'b0100;
        tick();
        chk("sb_gnt", gnt, 4'b0100); chk("sb_sel", sel, 2);
        chk("sb_busy", busy, 1); chk("sb_valid0", out_valid, 0);
        tick();
        chk("sb_b1_data", out_data, 4'hA); chk("sb_b1_valid", out_valid, 1);
        chk("sb_b1_gnt", gnt, 4'b0100);
        last = 4'b0100;
        tick();
        chk("sb_b2_data", out_data, 4'hA); chk("sb_b2_valid", out_valid, 1);
        chk("sb_rel_gnt", gnt, 0); chk("sb_rel_busy", busy, 0);
        req = 4'h0; last = 4'h0;
        tick();
        chk("sb_drain", out_valid, 0); chk("sb_sel_keep", sel, 2);
        // round-robin from ptr=0
        rst = 1'b1; tick(); rst = 1'b0;
        lane_data = 16'h4321; req = 4'hF; last = 4'hF;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("rr%0d_gnt", i), gnt, 4'b1 << (i % 4));
            chk($sformatf("rr%0d_sel", i), sel, i % 4);
            tick();
            chk($sformatf("rr%0d_data", i), out_data, (i % 4) + 1);
            chk($sformatf("rr%0d_idle", i), gnt, 0);
            chk($sformatf("rr%0d_selhold", i), sel, i % 4);
        end
        req = 4'h0; last = 4'h0;
        tick();
        // hold limit: requester 0 gets exactly four beats
        rst = 1'b1; tick(); rst = 1'b0;
        req = 4'b0011; last = 4'h0;
        tick();
        chk("hl_gnt0", gnt, 4'b0001);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("hl_b%0d_data", i), out_data, 1);
            chk($sformatf("hl_b%0d_gnt", i), gnt, (i == 4) ? 4'b0000 : 4'b0001);
        end
        tick();
        chk("hl_gnt1", gnt, 4'b0010); chk("hl_sel1", sel, 1); chk("hl_drain", out_valid, 0);
        // requester 1 drops its request before any beat: release, no beat
        req = 4'h0;
        tick();
        chk("ab_gnt", gnt, 0); chk("ab_valid", out_valid, 0); chk("ab_busy", busy, 0);
        // backpressure on requester 2 (ptr now 2)
        req = 4'b0100; lane_data = 16'h0500;
        tick();
        chk("bp_gnt", gnt, 4'b0100);
        tick();
        chk("bp_b1", out_data, 5);
        out_ready = 1'b0; lane_data = 16'h0600;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("bp_stall%0d_data", i), out_data, 5);
            chk($sformatf("bp_stall%0d_valid", i), out_valid, 1);
            chk($sformatf("bp_stall%0d_gnt", i), gnt, 4'b0100);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_b2", out_data, 6); chk("bp_b2_gnt", gnt, 4'b0100);
        lane_data = 16'h0700;
        tick();
        chk("bp_b3", out_data, 7); chk("bp_b3_gnt", gnt, 4'b0100);
        lane_data = 16'h0800;
        tick();
        chk("bp_b4", out_data, 8); chk("bp_b4_rel", gnt, 0);
        req = 4'h0;
        tick();
        chk("bp_drain", out_valid, 0);
        // reset mid-burst on requester 3 (ptr now 3)
        lane_data = 16'h9765; req = 4'b1000;
        tick();
        chk("mr_gnt", gnt, 4'b1000); chk("mr_sel", sel, 3);
        tick();
        chk("mr_data", out_data, 9); chk("mr_valid", out_valid, 1);
        rst = 1'b1;
        tick();
        chk("mr_rst_gnt", gnt, 0); chk("mr_rst_sel", sel, 0); chk("mr_rst_data", out_data, 0);
        chk("mr_rst_valid", out_valid, 0); chk("mr_rst_busy", busy, 0);
        rst = 1'b0; req = 4'hF;
        tick();
        chk("mr_ptr0", gnt, 4'b0001);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
